decode_pipe_stage: RTL

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage_pkg.sv | 38 +++
 rtl/decode_pipe_stage_if.sv | 52 +++++
 rtl/decode_pipe_stage_register_bank.sv | 25 ++
 rtl/decode_pipe_stage.sv | 93 +++++++++
 4 files changed

// File: rtl/decode_pipe_stage_pkg.sv
// decode_pipe_stage_pkg: opcodes, control bundle and sizing shared by the decode, execute and control stages
package decode_pipe_stage_pkg;
  localparam int DEF_SIZE = 32;
  localparam int DEF_NUM_REGISTERS = 32;
  localparam int DEF_SIZE_REG_DIR = $clog2(DEF_NUM_REGISTERS);
  localparam int DEF_SIZE_OP = 6;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LB = 6'h20;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWU = 6'h27;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctrl_t;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU};
  endfunction
  function automatic logic is_branch(input logic [5:0] op);
    return op == OP_BEQ || op == OP_BNE;
  endfunction
  // Immediate ALU ops occupy the whole 0x08-0x0F block
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c.memread = is_load(op);
    c.memwrite = op inside {OP_SB, OP_SH, OP_SW};
    c.regwrite = op == OP_RTYPE || op[5:3] == 3'b001 || c.memread;
    return c;
  endfunction
endpackage

// File: rtl/decode_pipe_stage_if.sv
// decode_pipe_stage_if: IF/ID slot, writeback/EX-MEM feedback, hazard/redirect and ID/EX bundle
interface decode_pipe_stage_if
  import decode_pipe_stage_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int SIZE_REG_DIR = DEF_SIZE_REG_DIR,
  parameter int SIZE_OP = DEF_SIZE_OP
);
  logic i_stall;
  logic i_flush;
  logic i_valid;
  logic [SIZE-1:0] i_instruction;
  logic [SIZE-1:0] i_pc_plus4;
  logic i_wb_we;
  logic [SIZE_REG_DIR-1:0] i_wb_dir;
  logic [SIZE-1:0] i_wb_data;
  logic i_ex_mem_we;
  logic [SIZE_REG_DIR-1:0] i_ex_mem_rd;
  logic i_ex_mem_rd_load;
  logic [SIZE-1:0] i_ex_mem_data;
  logic o_hold_if;
  logic o_branch_taken;
  logic [SIZE-1:0] o_branch_target;
  logic o_ex_valid;
  logic o_ex_regwrite;
  logic o_ex_memread;
  logic o_ex_memwrite;
  logic [SIZE_OP-1:0] o_ex_op;
  logic [SIZE-1:0] o_ex_reg_a;
  logic [SIZE-1:0] o_ex_reg_b;
  logic [SIZE-1:0] o_ex_imm;
  logic [SIZE-1:0] o_ex_funct_imm;
  logic [SIZE_REG_DIR-1:0] o_ex_rs;
  logic [SIZE_REG_DIR-1:0] o_ex_rt;
  logic [SIZE_REG_DIR-1:0] o_ex_rd;
  modport master (
    output i_stall, i_flush, i_valid, i_instruction, i_pc_plus4,
    output i_wb_we, i_wb_dir, i_wb_data,
    output i_ex_mem_we, i_ex_mem_rd, i_ex_mem_rd_load, i_ex_mem_data,
    input o_hold_if, o_branch_taken, o_branch_target,
    input o_ex_valid, o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_op,
    input o_ex_reg_a, o_ex_reg_b, o_ex_imm, o_ex_funct_imm, o_ex_rs, o_ex_rt, o_ex_rd
  );
  modport slave (
    input i_stall, i_flush, i_valid, i_instruction, i_pc_plus4,
    input i_wb_we, i_wb_dir, i_wb_data,
    input i_ex_mem_we, i_ex_mem_rd, i_ex_mem_rd_load, i_ex_mem_data,
    output o_hold_if, o_branch_taken, o_branch_target,
    output o_ex_valid, o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_op,
    output o_ex_reg_a, o_ex_reg_b, o_ex_imm, o_ex_funct_imm, o_ex_rs, o_ex_rt, o_ex_rd
  );
endinterface

// File: rtl/decode_pipe_stage_register_bank.sv
// decode_pipe_stage_register_bank: register file, one write port, two async read ports, r0 hardwired to zero
module decode_pipe_stage_register_bank #(
  parameter int SIZE = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR = $clog2(NUM_REGISTERS)
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [SIZE_REG_DIR-1:0] wr_dir,
  input logic [SIZE-1:0] wr_data,
  input logic [SIZE_REG_DIR-1:0] rd_dir_a,
  input logic [SIZE_REG_DIR-1:0] rd_dir_b,
  output logic [SIZE-1:0] rd_data_a,
  output logic [SIZE-1:0] rd_data_b
);
  logic [SIZE-1:0] regs [NUM_REGISTERS];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NUM_REGISTERS; i++) regs[i] <= '0;
    else if (we && wr_dir != '0)
      regs[wr_dir] <= wr_data;
  assign rd_data_a = rd_dir_a == '0 ? '0 : regs[rd_dir_a];
  assign rd_data_b = rd_dir_b == '0 ? '0 : regs[rd_dir_b];
endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: instruction decode with ID-stage forwarding, hazard holds, early branch resolution and ID/EX register
module decode_pipe_stage
  import decode_pipe_stage_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
  parameter int SIZE_REG_DIR = $clog2(NUM_REGISTERS),
  parameter int SIZE_OP = DEF_SIZE_OP
) (
  input logic clk,
  input logic rst,
  decode_pipe_stage_if.slave bus
);
  logic [5:0] op;
  logic [SIZE_REG_DIR-1:0] rs, rt, dest;
  logic [SIZE-1:0] bank_a, bank_b, reg_a, reg_b, imm, funct_imm;
  ctrl_t ctrl;
  logic load_use, branch_hz, hold, bubble, equal;
  function automatic logic hits(input logic [SIZE_REG_DIR-1:0] d, a, b);
    return d != '0 && (d == a || d == b);
  endfunction
  assign op = bus.i_instruction[31:26];
  assign rs = SIZE_REG_DIR'(bus.i_instruction[25:21]);
  assign rt = SIZE_REG_DIR'(bus.i_instruction[20:16]);
  assign dest = op == OP_RTYPE ? SIZE_REG_DIR'(bus.i_instruction[15:11]) : rt;
  assign ctrl = decode_ctrl(op);
  assign imm = {{(SIZE-16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};
  assign funct_imm = {{(SIZE-16){1'b0}}, bus.i_instruction[15:0]};
  decode_pipe_stage_register_bank #(
    .SIZE(SIZE),
    .NUM_REGISTERS(NUM_REGISTERS),
    .SIZE_REG_DIR(SIZE_REG_DIR)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .we(bus.i_wb_we),
    .wr_dir(bus.i_wb_dir),
    .wr_data(bus.i_wb_data),
    .rd_dir_a(rs),
    .rd_dir_b(rt),
    .rd_data_a(bank_a),
    .rd_data_b(bank_b)
  );
  // A load sitting in EX/MEM has no data yet, so it must not be forwarded
  assign reg_a = rs == '0 ? '0
               : bus.i_ex_mem_we && !bus.i_ex_mem_rd_load && bus.i_ex_mem_rd == rs ? bus.i_ex_mem_data
               : bus.i_wb_we && bus.i_wb_dir == rs ? bus.i_wb_data
               : bank_a;
  assign reg_b = rt == '0 ? '0
               : bus.i_ex_mem_we && !bus.i_ex_mem_rd_load && bus.i_ex_mem_rd == rt ? bus.i_ex_mem_data
               : bus.i_wb_we && bus.i_wb_dir == rt ? bus.i_wb_data
               : bank_b;
  assign load_use = bus.o_ex_valid && bus.o_ex_memread && hits(bus.o_ex_rd, rs, rt);
  // Branches compare in decode, so they also wait on an ALU result still in EX
  assign branch_hz = is_branch(op)
    && ((bus.o_ex_valid && bus.o_ex_regwrite && hits(bus.o_ex_rd, rs, rt))
     || (bus.i_ex_mem_we && bus.i_ex_mem_rd_load && hits(bus.i_ex_mem_rd, rs, rt)));
  assign hold = rst && bus.i_valid && (load_use || branch_hz);
  assign bubble = hold || bus.i_flush || !bus.i_valid;
  assign equal = reg_a == reg_b;
  assign bus.o_hold_if = hold;
  assign bus.o_branch_taken = rst && bus.i_valid && !hold && !bus.i_stall && !bus.i_flush
                           && ((op == OP_BEQ && equal) || (op == OP_BNE && !equal));
  assign bus.o_branch_target = bus.i_pc_plus4 + {imm[SIZE-3:0], 2'b00};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.o_ex_valid <= 1'b0;
      bus.o_ex_regwrite <= 1'b0;
      bus.o_ex_memread <= 1'b0;
      bus.o_ex_memwrite <= 1'b0;
      bus.o_ex_op <= '0;
      bus.o_ex_reg_a <= '0;
      bus.o_ex_reg_b <= '0;
      bus.o_ex_imm <= '0;
      bus.o_ex_funct_imm <= '0;
      bus.o_ex_rs <= '0;
      bus.o_ex_rt <= '0;
      bus.o_ex_rd <= '0;
    end else if (!bus.i_stall) begin
      bus.o_ex_valid <= !bubble;
      bus.o_ex_regwrite <= !bubble && ctrl.regwrite && dest != '0;
      bus.o_ex_memread <= !bubble && ctrl.memread;
      bus.o_ex_memwrite <= !bubble && ctrl.memwrite;
      bus.o_ex_op <= bubble ? '0 : SIZE_OP'(op);
      bus.o_ex_reg_a <= bubble ? '0 : reg_a;
      bus.o_ex_reg_b <= bubble ? '0 : reg_b;
      bus.o_ex_imm <= bubble ? '0 : imm;
      bus.o_ex_funct_imm <= bubble ? '0 : funct_imm;
      bus.o_ex_rs <= bubble ? '0 : rs;
      bus.o_ex_rt <= bubble ? '0 : rt;
      bus.o_ex_rd <= bubble ? '0 : dest;
    end
endmodule
